slice_column_renderer: RTL
==========================

Name: slice_column_renderer

Overview:
- Issues per-column slice-height requests to the slice-height calculator.
- For each column it pulses begin_calc, waits for end_calc, then latches slice_size.
- It then rasterises one full vertical column (ceiling, wall, floor) into the VGA adapter's pixel-write port.
- It sits between the frame-level game controller (start_frame/frame_done) and the per-column height calculator.

Parameters:
SCREEN_W, 160, columns per frame (column_count runs 0..SCREEN_W-1)
SCREEN_H, 120, rows per column (y runs 0..SCREEN_H-1)
CEIL_COLOUR, 3'b001, colour above wall
FLOOR_COLOUR, 3'b010, colour below wall
WALL_COLOUR, 3'b111, wall colour
WALL_DARK_COLOUR, 3'b100, far-wall colour (optional feature only)
SHADE_THRESH, 30, height below which the wall is shaded (optional feature only)

Ports:
clock  in  1  system clock
resetn  in  1  reset; synchronous, active-low
start_frame  in  1  1-cycle request to render one frame
frame_busy  out  1  high from accepted start_frame until frame_done
frame_done  out  1  1-cycle pulse after the last pixel of column SCREEN_W-1
column_count  out  8  current column index, held stable during the request/wait
begin_calc  out  1  1-cycle pulse starting a height calculation
end_calc  in  1  calculator completion; slice_size is valid in the same cycle
slice_size  in  7  projected wall height in pixels (0..127)
x  out  8  pixel column (= column_count)
y  out  7  pixel row
colour  out  3  pixel colour
plot  out  1  pixel write strobe, one pixel per cycle

Behaviour:
- All registers update on posedge clock.
- resetn=0 for one edge forces:
  - state S_IDLE
  - column_count=0, x=0, y=0, colour=0
  - plot=0, begin_calc=0, frame_busy=0, frame_done=0
- Reset mid-frame aborts the frame immediately and produces no frame_done.
- S_IDLE:
  - start_frame=1 -> S_REQ with column_count=0 and frame_busy=1.
  - start_frame is ignored in every other state.
- S_REQ: begin_calc=1 for exactly one cycle -> S_WAIT.
- S_WAIT:
  - end_calc is sampled only here; an end_calc seen in S_REQ is ignored.
  - end_calc=1 -> latch h = min(slice_size, SCREEN_H) -> S_SETUP.
  - There is no timeout (see optional feature); the block waits indefinitely.
- S_SETUP (1 cycle):
  - top = (SCREEN_H - h) >> 1
  - bottom = top + h
  - y=0
  - -> S_DRAW
- S_DRAW:
  - plot=1 every cycle, with x=column_count.
  - colour = CEIL_COLOUR if y<top; WALL_COLOUR if top<=y<bottom; FLOOR_COLOUR if y>=bottom.
  - x/y/colour/plot are registered together, so the outputs are coherent in the same cycle.
  - After the cycle with y=SCREEN_H-1: plot drops next cycle -> S_NEXT.
- S_NEXT:
  - If column_count==SCREEN_W-1: frame_done=1 for 1 cycle, frame_busy=0 -> S_IDLE, column_count returns to 0.
  - Otherwise: column_count+1 -> S_REQ.
- Per-column latency = 1 (REQ) + Nwait + 1 (SETUP) + SCREEN_H (DRAW) + 1 (NEXT), where Nwait is the number of S_WAIT cycles including the end_calc cycle.
- h=0 (no wall found): top=bottom=SCREEN_H/2; no wall pixels are drawn.
- slice_size > SCREEN_H: clamped, so the whole column is wall.
- Odd (SCREEN_H-h): top is rounded down, giving one extra floor row.
- column_count width is 8 bits; SCREEN_W must be <=256. The counter never wraps within a frame.
- plot is never asserted outside S_DRAW, and begin_calc is never asserted outside S_REQ.

Optional Feature:
- Macro: SLICE_WALL_SHADE_EN
- Defined: in S_DRAW, wall rows use WALL_DARK_COLOUR when h < SHADE_THRESH, and WALL_COLOUR otherwise. The comparison uses the clamped h latched in S_WAIT.
- Undefined: wall rows always use WALL_COLOUR; WALL_DARK_COLOUR and SHADE_THRESH are unused.
- Timing is identical with and without the macro.

Test Plan:
- Reset held 2 cycles mid-S_DRAW, then released -> all outputs 0, state idle; next start_frame begins at column 0 with no frame_done from the aborted frame.
- start_frame, calculator returns slice_size=40 after 3 cycles -> column 0 emits 120 plots:
  - y 0..39 CEIL_COLOUR
  - y 40..79 WALL_COLOUR
  - y 80..119 FLOOR_COLOUR
  - x=0 throughout
- slice_size=0 -> y 0..59 CEIL_COLOUR, y 60..119 FLOOR_COLOUR; slice_size=127 -> all 120 rows WALL_COLOUR.
- slice_size=41 -> top=39, bottom=80:
  - y 0..38 ceiling
  - y 39..79 wall
  - y 80..119 floor
- Full frame with SCREEN_W=4 and constant end_calc latency of 2:
  - exactly 4 begin_calc pulses with column_count 0,1,2,3
  - 480 plots total
  - one frame_done pulse, 4*(1+2+1+120+1)=500 cycles after the first S_REQ
  - start_frame pulses mid-frame are ignored
- With SLICE_WALL_SHADE_EN: slice_size=20 -> wall rows (top=50, y 50..69) use WALL_DARK_COLOUR; slice_size=30 -> wall rows use WALL_COLOUR.

Source files
------------

// File: rtl/slice_column_renderer.sv
// Per-column slice renderer: requests a wall height, then rasterises one column.
// Optional wall shading for short (distant) slices: define SLICE_WALL_SHADE_EN.
module slice_column_renderer #(
    parameter int         SCREEN_W     = 160,
    parameter int         SCREEN_H     = 120,
    parameter logic [2:0] CEIL_COLOUR  = 3'b001,
    parameter logic [2:0] FLOOR_COLOUR = 3'b010,
`ifdef SLICE_WALL_SHADE_EN
    parameter logic [2:0] WALL_DARK_COLOUR = 3'b100,
    parameter int         SHADE_THRESH     = 30,
`endif
    parameter logic [2:0] WALL_COLOUR  = 3'b111
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start_frame,
    output logic       frame_busy,
    output logic       frame_done,
    output logic [7:0] column_count,
    output logic       begin_calc,
    input  logic       end_calc,
    input  logic [6:0] slice_size,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot
);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT, S_SETUP, S_DRAW, S_NEXT
    } state_t;

    localparam logic [6:0] H7       = 7'(SCREEN_H);
    localparam logic [7:0] H8       = 8'(SCREEN_H);
    localparam logic [6:0] LAST_Y   = 7'(SCREEN_H - 1);
    localparam logic [7:0] LAST_COL = 8'(SCREEN_W - 1);

    state_t     state, state_nx;
    logic [6:0] h, h_nx;
    logic [7:0] top, bottom;
    logic [7:0] col_nx, x_nx;
    logic [6:0] y_nx;
    logic [2:0] colour_nx;
    logic       plot_nx, begin_nx, busy_nx, done_nx;

    // h is stable from SETUP through DRAW, so the band edges can stay combinational
    assign top    = (H8 - {1'b0, h}) >> 1;
    assign bottom = top + {1'b0, h};

    function automatic logic [2:0] pick(
        input logic [6:0] row,
        input logic [7:0] t,
        input logic [7:0] b,
        input logic [6:0] hh
    );
        logic [2:0] c;
        if ({1'b0, row} < t) begin
            c = CEIL_COLOUR;
        end else if ({1'b0, row} < b) begin
`ifdef SLICE_WALL_SHADE_EN
            c = (32'(hh) < SHADE_THRESH) ? WALL_DARK_COLOUR : WALL_COLOUR;
`else
            c = WALL_COLOUR;
`endif
        end else begin
            c = FLOOR_COLOUR;
        end
        return c;
    endfunction

    always_comb begin
        state_nx  = state;
        h_nx      = h;
        col_nx    = column_count;
        x_nx      = x;
        y_nx      = y;
        colour_nx = colour;
        plot_nx   = 1'b0;
        begin_nx  = 1'b0;
        busy_nx   = frame_busy;
        done_nx   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start_frame) begin
                    state_nx = S_REQ;
                    col_nx   = '0;
                    busy_nx  = 1'b1;
                    begin_nx = 1'b1;
                end
            end
            S_REQ: state_nx = S_WAIT;
            S_WAIT: begin
                if (end_calc) begin
                    h_nx     = (slice_size > H7) ? H7 : slice_size;
                    state_nx = S_SETUP;
                end
            end
            S_SETUP: begin
                state_nx  = S_DRAW;
                plot_nx   = 1'b1;
                x_nx      = column_count;
                y_nx      = '0;
                colour_nx = pick(7'd0, top, bottom, h);
            end
            S_DRAW: begin
                if (y == LAST_Y) begin
                    state_nx = S_NEXT;
                end else begin
                    plot_nx   = 1'b1;
                    y_nx      = y + 7'd1;
                    colour_nx = pick(y + 7'd1, top, bottom, h);
                end
            end
            S_NEXT: begin
                if (column_count == LAST_COL) begin
                    state_nx = S_IDLE;
                    col_nx   = '0;
                    busy_nx  = 1'b0;
                    done_nx  = 1'b1;
                end else begin
                    state_nx = S_REQ;
                    col_nx   = column_count + 8'd1;
                    begin_nx = 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state        <= S_IDLE;
            h            <= '0;
            column_count <= '0;
            x            <= '0;
            y            <= '0;
            colour       <= '0;
            plot         <= 1'b0;
            begin_calc   <= 1'b0;
            frame_busy   <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            state        <= state_nx;
            h            <= h_nx;
            column_count <= col_nx;
            x            <= x_nx;
            y            <= y_nx;
            colour       <= colour_nx;
            plot         <= plot_nx;
            begin_calc   <= begin_nx;
            frame_busy   <= busy_nx;
            frame_done   <= done_nx;
        end
    end

endmodule
